// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the two-port FP multiplier arbiter.
// State encoding, canonical NaN and fflags bit positions.
package fp_mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant selection.
// Ties go to the port that did not win last time.
module rr_arbiter_2
    import fp_mul_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_o
);

    // Pick the single valid port, or alternate on a tie
    always_comb begin
        any_o   = |valid_i;
        grant_o = PORT0;
        case (valid_i)
            2'b01:   grant_o = PORT0;
            2'b10:   grant_o = PORT1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = PORT0;
        endcase
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one multi-cycle FP multiplier between two requesters.
// Round-robin grant, operand capture, per-port responses, watchdog abort.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int FLAG_W         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [2:0]        req0_rm,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [2:0]        req1_rm,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic [FLAG_W-1:0] rsp0_flags,
    output logic              rsp0_timeout,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic [FLAG_W-1:0] rsp1_flags,
    output logic              rsp1_timeout,
    output logic              mul_start,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    output logic [2:0]        mul_rm,
    input  logic              mul_done,
    input  logic [WIDTH-1:0]  mul_result,
    input  logic [FLAG_W-1:0] mul_flags
);

    localparam logic [WIDTH-1:0]  NAN_RES  = WIDTH'(CANON_NAN_SP);
    localparam logic [FLAG_W-1:0] NV_FLAGS = FLAG_W'(1) << FLAG_NV;
    localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, last_q;
    logic [7:0]        cnt_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        rm_q;
    logic [WIDTH-1:0]  res0_q, res1_q;
    logic [FLAG_W-1:0] flg0_q, flg1_q;
    logic              to0_q, to1_q;

    logic              grant, any_valid;
    logic              accept, expire, wr_rsp;
    logic [WIDTH-1:0]  res_d;
    logic [FLAG_W-1:0] flg_d;
    logic              to_d;

    rr_arbiter_2 u_rr (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .any_o        (any_valid)
    );

    assign accept = (state_q == ST_IDLE) && any_valid;
    assign expire = (cnt_q == CNT_LAST);
    assign wr_rsp = (state_q == ST_WAIT) && (mul_done || expire);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a completion beats a same-cycle expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mul_done || expire) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and pulse outputs decoded from state
    always_comb begin
        req0_ready   = accept && (grant == PORT0);
        req1_ready   = accept && (grant == PORT1);
        mul_start    = (state_q == ST_ISSUE);
        rsp0_valid   = (state_q == ST_RESP) && (owner_q == PORT0);
        rsp1_valid   = (state_q == ST_RESP) && (owner_q == PORT1);
        rsp0_timeout = rsp0_valid && to0_q;
        rsp1_timeout = rsp1_valid && to1_q;
    end

    // Response payload: real product or canonical-NaN abort
    always_comb begin
        res_d = mul_done ? mul_result : NAN_RES;
        flg_d = mul_done ? mul_flags  : NV_FLAGS;
        to_d  = !mul_done;
    end

    // Grant bookkeeping, operand capture and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= PORT0;
            last_q  <= PORT1;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant;
                last_q  <= grant;
                a_q     <= grant ? req1_a  : req0_a;
                b_q     <= grant ? req1_b  : req0_b;
                rm_q    <= grant ? req1_rm : req0_rm;
            end
            if (state_q == ST_ISSUE) cnt_q <= '0;
            else if ((state_q == ST_WAIT) && !mul_done && !expire)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    // Per-port response registers; only the owner is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0_q <= '0;
            res1_q <= '0;
            flg0_q <= '0;
            flg1_q <= '0;
            to0_q  <= 1'b0;
            to1_q  <= 1'b0;
        end else if (wr_rsp) begin
            if (owner_q == PORT0) begin
                res0_q <= res_d;
                flg0_q <= flg_d;
                to0_q  <= to_d;
            end else begin
                res1_q <= res_d;
                flg1_q <= flg_d;
                to1_q  <= to_d;
            end
        end
    end

    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign mul_rm      = rm_q;
    assign rsp0_result = res0_q;
    assign rsp1_result = res1_q;
    assign rsp0_flags  = flg0_q;
    assign rsp1_flags  = flg1_q;

endmodule
